packet_rx_framer: RTL and testbench

PACKET_RX_FRAMER -- requirements
Module: packet_rx_framer

---
 rtl/packet_pkg.sv | 31 +++
 rtl/packet_timeout_timer.sv | 31 +++
 rtl/packet_rx_framer.sv | 201 ++++++++++++++++++++
 tb/tb_packet_rx_framer.sv | 581 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_pkg.sv
// Shared constants, framer state encoding and opcode helpers
// for the UART packet receive path.
package packet_pkg;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_MUL  = 8'h02;
    localparam logic [7:0] OP_DIV  = 8'h03;

    // Opcode, reserved, length LSB, length MSB.
    localparam int HDR_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RSVD    = 3'd1,
        ST_LEN_L   = 3'd2,
        ST_LEN_H   = 3'd3,
        ST_HDR     = 3'd4,
        ST_PAYLOAD = 3'd5,
        ST_DROP    = 3'd6
    } rx_state_e;

    function automatic logic op_known(input logic [7:0] op);
        return op inside {OP_ECHO, OP_ADD, OP_MUL, OP_DIV};
    endfunction

    function automatic logic op_is_arith(input logic [7:0] op);
        return op inside {OP_ADD, OP_MUL, OP_DIV};
    endfunction

endpackage

// File: rtl/packet_timeout_timer.sv
// Idle-cycle watchdog: counts enabled cycles with no activity.
// Ports: clk_i, rst_ni, enable_i, clear_i, expired_o (combinational).
module packet_timeout_timer #(
    parameter int CYCLES = 4096
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt_q;

    // Fires during the CYCLES-th consecutive idle cycle.
    assign expired_o = enable_i && !clear_i
                    && (cnt_q == CW'(CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (!enable_i || clear_i || expired_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/packet_rx_framer.sv
// Parses 4-byte packet headers from a UART byte stream, validates
// opcode/length, then passes the payload through or drops it.
// Ports: clk_i, rst_ni, s_axis_* (RX bytes in), hdr_* (header
// channel), m_axis_* (payload out), err_o pulse, err_count_o.
// Option: PACKET_RX_TIMEOUT_EN adds an idle abort inside headers/drops.
module packet_rx_framer
    import packet_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  hdr_valid_o,
    input  logic                  hdr_ready_i,
    output logic [7:0]            hdr_opcode_o,
    output logic [15:0]           hdr_len_o,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  err_o,
    output logic [15:0]           err_count_o
);

    rx_state_e   state_q;
    rx_state_e   state_d;
    logic        out_en_q;
    logic [7:0]  opcode_q;
    logic [7:0]  len_lo_q;
    // Raw packet length until evaluated, then the payload count.
    logic [15:0] len_q;
    logic        len_done_q;
    logic [15:0] remain_q;
    logic        err_q;
    logic        err_d;
    logic [15:0] err_cnt_q;
    logic [7:0]  rx_byte;
    logic [15:0] eval_pay;
    logic        rx_fire;
    logic        timeout;

    assign rx_byte      = s_axis_tdata[7:0];
    assign rx_fire      = s_axis_tvalid && s_axis_tready;
    assign eval_pay     = len_q - 16'(HDR_BYTES);
    assign m_axis_tdata = s_axis_tdata;
    assign hdr_opcode_o = opcode_q;
    assign hdr_len_o    = len_q;
    assign err_o        = err_q;
    assign err_count_o  = err_cnt_q;

`ifdef PACKET_RX_TIMEOUT_EN
    logic tmo_en;

    assign tmo_en = (state_q == ST_RSVD)
                 || (state_q == ST_LEN_L)
                 || (state_q == ST_DROP)
                 || ((state_q == ST_LEN_H) && !len_done_q);

    packet_timeout_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .enable_i  (tmo_en),
        .clear_i   (rx_fire),
        .expired_o (timeout)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // Handshake outputs. out_en_q keeps tready low while in reset.
    always_comb begin
        s_axis_tready = 1'b0;
        hdr_valid_o   = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_RSVD, ST_LEN_L, ST_DROP: begin
                s_axis_tready = out_en_q;
            end
            ST_LEN_H: begin
                s_axis_tready = !len_done_q;
            end
            ST_HDR: begin
                hdr_valid_o = 1'b1;
            end
            ST_PAYLOAD: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tlast  = (remain_q == 16'd1);
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_fire) begin
                    if (op_known(rx_byte)) begin
                        state_d = ST_RSVD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RSVD: begin
                if (rx_fire) state_d = ST_LEN_L;
            end
            ST_LEN_L: begin
                if (rx_fire) state_d = ST_LEN_H;
            end
            ST_LEN_H: begin
                // Evaluation cycle follows the MSB byte.
                if (len_done_q) begin
                    if (len_q < 16'(HDR_BYTES)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (op_is_arith(opcode_q)
                                 && (eval_pay < 16'd8
                                     || eval_pay[1:0] != 2'b00)) begin
                        err_d   = 1'b1;
                        state_d = (eval_pay == 16'd0) ? ST_IDLE
                                                      : ST_DROP;
                    end else begin
                        state_d = ST_HDR;
                    end
                end
            end
            ST_HDR: begin
                if (hdr_ready_i) begin
                    state_d = (len_q == 16'd0) ? ST_IDLE
                                               : ST_PAYLOAD;
                end
            end
            ST_PAYLOAD, ST_DROP: begin
                if (rx_fire && remain_q == 16'd1) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (timeout) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            out_en_q   <= 1'b0;
            opcode_q   <= '0;
            len_lo_q   <= '0;
            len_q      <= '0;
            len_done_q <= 1'b0;
            remain_q   <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            out_en_q <= 1'b1;
            err_q    <= err_d;
            if (err_d && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
            if (state_q == ST_IDLE && rx_fire) begin
                opcode_q <= rx_byte;
            end
            if (state_q == ST_LEN_L && rx_fire) begin
                len_lo_q <= rx_byte;
            end
            if (state_q == ST_LEN_H && rx_fire) begin
                len_q      <= {rx_byte, len_lo_q};
                len_done_q <= 1'b1;
            end
            if (state_q == ST_LEN_H && len_done_q) begin
                len_done_q <= 1'b0;
                len_q      <= eval_pay;
                remain_q   <= eval_pay;
            end
            if (state_q == ST_HDR && hdr_ready_i) begin
                remain_q <= len_q;
            end
            if ((state_q == ST_PAYLOAD || state_q == ST_DROP)
                && rx_fire) begin
                remain_q <= remain_q - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_packet_rx_framer.sv
// Self-checking bench for packet_rx_framer: directed scenarios plus
// a randomized packet stream checked against a packet-level model.
module tb_packet_rx_framer;

    localparam int DW  = 8;
    localparam int TMO = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          hdr_valid_o;
    logic          hdr_ready_i = 1'b0;
    logic [7:0]    hdr_opcode_o;
    logic [15:0]   hdr_len_o;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic          err_o;
    logic [15:0]   err_count_o;

    packet_rx_framer #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .hdr_valid_o   (hdr_valid_o),
        .hdr_ready_i   (hdr_ready_i),
        .hdr_opcode_o  (hdr_opcode_o),
        .hdr_len_o     (hdr_len_o),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .err_o         (err_o),
        .err_count_o   (err_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] len;
    } hdr_t;

    int checks = 0;
    int errors = 0;
    int total_err_exp = 0;

    hdr_t       obs_hdr[$];
    logic [8:0] obs_pay[$];
    int         obs_err = 0;
    int         obs_hvld = 0;
    int         mirror_bad = 0;

    hdr_t       exp_hdr[$];
    logic [8:0] exp_pay[$];
    int         exp_err;

    logic [7:0] tx_q[$];
    int m_mode = 0;
    int h_mode = 0;

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (hdr_valid_o) obs_hvld <= obs_hvld + 1;
            if (hdr_valid_o && hdr_ready_i)
                obs_hdr.push_back({hdr_opcode_o, hdr_len_o});
            if (m_axis_tvalid && m_axis_tready)
                obs_pay.push_back({m_axis_tlast, m_axis_tdata});
            if (m_axis_tvalid && (s_axis_tready !== m_axis_tready
                                  || m_axis_tdata !== s_axis_tdata))
                mirror_bad <= mirror_bad + 1;
            if (err_o) obs_err <= obs_err + 1;
        end
    end

    // Ready drivers: 0 always high, 1 random, 2 toggle.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            case (m_mode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = ~m_axis_tready;
            endcase
            case (h_mode)
                0: hdr_ready_i = 1'b1;
                default: hdr_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic clear_obs();
        obs_hdr.delete();
        obs_pay.delete();
        obs_err = 0;
        obs_hvld = 0;
        mirror_bad = 0;
        tx_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        s_axis_tdata = b;
        s_axis_tvalid = 1'b1;
        forever begin
            @(negedge clk_i);
            if (s_axis_tready) break;
            n++;
            if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL send_stall: byte %02h waited %0d cycles, required acceptance", b, n);
                break;
            end
        end
        @(posedge clk_i);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drive_tx(input int max_gap);
        foreach (tx_q[i]) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk_i);
                #1;
            end
            send_byte(tx_q[i]);
        end
    endtask

    task automatic settle();
        m_mode = 0;
        h_mode = 0;
        repeat (8) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic push_pkt(input logic [7:0] op, input int len,
                            input int npay);
        tx_q.push_back(op);
        tx_q.push_back(8'($urandom));
        tx_q.push_back(8'(len));
        tx_q.push_back(8'(len >> 8));
        for (int k = 0; k < npay; k++) tx_q.push_back(8'($urandom));
    endtask

    // Packet-level reference: walks tx_q by the framing rules.
    task automatic model_stream();
        int i;
        int n;
        int len;
        int pl;
        logic [7:0] op;
        i = 0;
        n = tx_q.size();
        exp_hdr.delete();
        exp_pay.delete();
        exp_err = 0;
        while (i < n) begin
            op = tx_q[i];
            i++;
            if (!(op inside {8'hEC, 8'h01, 8'h02, 8'h03})) begin
                exp_err++;
                continue;
            end
            len = int'({tx_q[i+2], tx_q[i+1]});
            i += 3;
            if (len < 4) begin
                exp_err++;
                continue;
            end
            pl = len - 4;
            if (op != 8'hEC && (pl < 8 || pl % 4 != 0)) begin
                exp_err++;
                i += pl;
                continue;
            end
            exp_hdr.push_back({op, 16'(pl)});
            for (int k = 0; k < pl; k++)
                exp_pay.push_back({1'(k == pl - 1), tx_q[i+k]});
            i += pl;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #1;
        checks++;
        if (s_axis_tready !== 1'b0 || hdr_valid_o !== 1'b0
            || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: tready=%b hvld=%b mvld=%b tlast=%b, required all 0",
                     s_axis_tready, hdr_valid_o, m_axis_tvalid, m_axis_tlast);
        end
        checks++;
        if (err_o !== 1'b0 || err_count_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_err: err=%b cnt=%0d, required 0/0", err_o, err_count_o);
        end
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        total_err_exp = 0;
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: tready=%b, required 1", s_axis_tready);
        end
    endtask

    task automatic test_add();
        logic [7:0] pay[8];
        clear_obs();
        push_pkt(8'h01, 12, 0);
        for (int k = 0; k < 8; k++) begin
            pay[k] = 8'($urandom);
            tx_q.push_back(pay[k]);
        end
        drive_tx(0);
        settle();
        checks++;
        if (obs_hdr.size() != 1) begin
            errors++;
            $display("FAIL add_hdr_cnt: %0d, required 1", obs_hdr.size());
        end else begin
            checks++;
            if (obs_hdr[0] !== {8'h01, 16'd8}) begin
                errors++;
                $display("FAIL add_hdr: %h, required %h", obs_hdr[0], {8'h01, 16'd8});
            end
        end
        checks++;
        if (obs_pay.size() != 8) begin
            errors++;
            $display("FAIL add_pay_cnt: %0d, required 8", obs_pay.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (obs_pay[k] !== {1'(k == 7), pay[k]}) begin
                    errors++;
                    $display("FAIL add_pay[%0d]: %h, required %h", k, obs_pay[k], {1'(k == 7), pay[k]});
                end
            end
        end
        checks++;
        if (obs_err != 0) begin
            errors++;
            $display("FAIL add_err: %0d, required 0", obs_err);
        end
    endtask

    task automatic test_drop();
        clear_obs();
        push_pkt(8'h02, 13, 9);
        drive_tx(1);
        settle();
        total_err_exp += 1;
        checks++;
        if (obs_err != 1 || obs_hvld != 0 || obs_pay.size() != 0) begin
            errors++;
            $display("FAIL drop: err=%0d hvld=%0d pay=%0d, required 1/0/0",
                     obs_err, obs_hvld, obs_pay.size());
        end
        checks++;
        if (err_count_o !== 16'(total_err_exp)) begin
            errors++;
            $display("FAIL drop_cnt: %0d, required %0d", err_count_o, total_err_exp);
        end
        clear_obs();
        push_pkt(8'hEC, 6, 2);
        drive_tx(1);
        settle();
        checks++;
        if (obs_hdr.size() != 1 || obs_pay.size() != 2 || obs_err != 0) begin
            errors++;
            $display("FAIL drop_next: hdr=%0d pay=%0d err=%0d, required 1/2/0",
                     obs_hdr.size(), obs_pay.size(), obs_err);
        end else begin
            checks++;
            if (obs_hdr[0] !== {8'hEC, 16'd2}) begin
                errors++;
                $display("FAIL drop_next_hdr: %h, required %h", obs_hdr[0], {8'hEC, 16'd2});
            end
        end
    endtask

    task automatic test_echo_hdr_only();
        clear_obs();
        push_pkt(8'hEC, 4, 0);
        drive_tx(2);
        settle();
        checks++;
        if (obs_hdr.size() != 1 || obs_pay.size() != 0 || obs_err != 0) begin
            errors++;
            $display("FAIL echo0: hdr=%0d pay=%0d err=%0d, required 1/0/0",
                     obs_hdr.size(), obs_pay.size(), obs_err);
        end else begin
            checks++;
            if (obs_hdr[0] !== {8'hEC, 16'd0}) begin
                errors++;
                $display("FAIL echo0_hdr: %h, required %h", obs_hdr[0], {8'hEC, 16'd0});
            end
        end
        checks++;
        if (s_axis_tready !== 1'b1 || hdr_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL echo0_idle: tready=%b hvld=%b, required 1/0", s_axis_tready, hdr_valid_o);
        end
    endtask

    task automatic test_echo_backpressure();
        logic [7:0] pay[3];
        clear_obs();
        push_pkt(8'hEC, 7, 0);
        for (int k = 0; k < 3; k++) begin
            pay[k] = 8'($urandom);
            tx_q.push_back(pay[k]);
        end
        m_mode = 2;
        drive_tx(0);
        settle();
        checks++;
        if (obs_pay.size() != 3) begin
            errors++;
            $display("FAIL bp_cnt: %0d, required 3", obs_pay.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_pay[k] !== {1'(k == 2), pay[k]}) begin
                    errors++;
                    $display("FAIL bp_pay[%0d]: %h, required %h", k, obs_pay[k], {1'(k == 2), pay[k]});
                end
            end
        end
        checks++;
        if (mirror_bad != 0) begin
            errors++;
            $display("FAIL bp_mirror: %0d bad cycles, required 0", mirror_bad);
        end
    endtask

`ifdef PACKET_RX_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        clear_obs();
        send_byte(8'h01);
        send_byte(8'h00);
        while (n < 40) begin
            @(negedge clk_i);
            n++;
            if (err_o) break;
        end
        total_err_exp += 1;
        checks++;
        if (n < 16 || n > 18) begin
            errors++;
            $display("FAIL timeout_at: cycle %0d, required 16..18", n);
        end
        settle();
        clear_obs();
        push_pkt(8'h03, 12, 8);
        drive_tx(1);
        settle();
        checks++;
        if (obs_hdr.size() != 1 || obs_pay.size() != 8 || obs_err != 0) begin
            errors++;
            $display("FAIL timeout_next: hdr=%0d pay=%0d err=%0d, required 1/8/0",
                     obs_hdr.size(), obs_pay.size(), obs_err);
        end else begin
            checks++;
            if (obs_hdr[0] !== {8'h03, 16'd8}) begin
                errors++;
                $display("FAIL timeout_hdr: %h, required %h", obs_hdr[0], {8'h03, 16'd8});
            end
        end
    endtask
`else
    task automatic test_stall();
        clear_obs();
        send_byte(8'h01);
        send_byte(8'h00);
        repeat (60) @(posedge clk_i);
        #1;
        checks++;
        if (obs_err != 0) begin
            errors++;
            $display("FAIL stall_err: %0d, required 0", obs_err);
        end
        tx_q.push_back(8'h0C);
        tx_q.push_back(8'h00);
        for (int k = 0; k < 8; k++) tx_q.push_back(8'($urandom));
        drive_tx(0);
        settle();
        checks++;
        if (obs_hdr.size() != 1 || obs_pay.size() != 8) begin
            errors++;
            $display("FAIL stall_pkt: hdr=%0d pay=%0d, required 1/8",
                     obs_hdr.size(), obs_pay.size());
        end else begin
            checks++;
            if (obs_hdr[0] !== {8'h01, 16'd8}) begin
                errors++;
                $display("FAIL stall_hdr: %h, required %h", obs_hdr[0], {8'h01, 16'd8});
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        clear_obs();
        push_pkt(8'h01, 12, 3);
        drive_tx(0);
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0
            || err_o !== 1'b0 || err_count_o !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_out: tready=%b mvld=%b err=%b cnt=%0d, required 0",
                     s_axis_tready, m_axis_tvalid, err_o, err_count_o);
        end
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        total_err_exp = 0;
        settle();
        checks++;
        if (obs_err != 0 || obs_pay.size() != 3
            || obs_pay[0][8] || obs_pay[1][8] || obs_pay[2][8]) begin
            errors++;
            $display("FAIL rstmid_abandon: err=%0d pay=%0d, required 0 err, 3 bytes without tlast",
                     obs_err, obs_pay.size());
        end
        clear_obs();
        push_pkt(8'hEC, 5, 1);
        drive_tx(0);
        settle();
        checks++;
        if (obs_pay.size() != 1 || obs_hdr.size() != 1) begin
            errors++;
            $display("FAIL rstmid_next: hdr=%0d pay=%0d, required 1/1",
                     obs_hdr.size(), obs_pay.size());
        end else begin
            checks++;
            if (obs_pay[0] !== {1'b1, tx_q[4]}) begin
                errors++;
                $display("FAIL rstmid_byte: %h, required %h", obs_pay[0], {1'b1, tx_q[4]});
            end
        end
    endtask

    task automatic test_random();
        int kind;
        int pl;
        logic [7:0] b;
        clear_obs();
        for (int p = 0; p < 30; p++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                do b = 8'($urandom_range(4, 255)); while (b == 8'hEC);
                tx_q.push_back(b);
            end else if (kind == 1) begin
                push_pkt(8'($urandom_range(1, 3)), $urandom_range(0, 3), 0);
            end else if (kind == 2) begin
                pl = $urandom_range(0, 30);
                if (pl >= 8 && pl % 4 == 0) pl = pl + 1;
                push_pkt(8'($urandom_range(1, 3)), pl + 4, pl);
            end else if (kind <= 4) begin
                pl = $urandom_range(0, 12);
                push_pkt(8'hEC, pl + 4, pl);
            end else begin
                pl = 4 * $urandom_range(2, 6);
                push_pkt(8'($urandom_range(1, 3)), pl + 4, pl);
            end
        end
        model_stream();
        m_mode = 1;
        h_mode = 1;
        drive_tx(3);
        settle();
        total_err_exp += exp_err;
        checks++;
        if (obs_hdr.size() != exp_hdr.size()) begin
            errors++;
            $display("FAIL rnd_hdr_cnt: %0d, required %0d", obs_hdr.size(), exp_hdr.size());
        end else begin
            foreach (exp_hdr[i]) begin
                checks++;
                if (obs_hdr[i] !== exp_hdr[i]) begin
                    errors++;
                    $display("FAIL rnd_hdr[%0d]: %h, required %h", i, obs_hdr[i], exp_hdr[i]);
                end
            end
        end
        checks++;
        if (obs_pay.size() != exp_pay.size()) begin
            errors++;
            $display("FAIL rnd_pay_cnt: %0d, required %0d", obs_pay.size(), exp_pay.size());
        end else begin
            foreach (exp_pay[i]) begin
                checks++;
                if (obs_pay[i] !== exp_pay[i]) begin
                    errors++;
                    $display("FAIL rnd_pay[%0d]: %h, required %h", i, obs_pay[i], exp_pay[i]);
                end
            end
        end
        checks++;
        if (obs_err != exp_err || err_count_o !== 16'(total_err_exp)) begin
            errors++;
            $display("FAIL rnd_err: pulses=%0d cnt=%0d, required %0d/%0d",
                     obs_err, err_count_o, exp_err, total_err_exp);
        end
        checks++;
        if (mirror_bad != 0) begin
            errors++;
            $display("FAIL rnd_mirror: %0d bad cycles, required 0", mirror_bad);
        end
    endtask

    task automatic test_saturate();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        s_axis_tdata = 8'h55;
        s_axis_tvalid = 1'b1;
        repeat (65534) @(posedge clk_i);
        #1;
        checks++;
        if (err_count_o !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_pre: %h, required fffe", err_count_o);
        end
        repeat (70000 - 65534) @(posedge clk_i);
        #1;
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (err_count_o !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_final: %h, required ffff", err_count_o);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_drop();
        test_echo_hdr_only();
        test_echo_backpressure();
`ifdef PACKET_RX_TIMEOUT_EN
        test_timeout();
`else
        test_stall();
`endif
        test_reset_mid();
        test_random();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
